// File: rtl/compar_pkg.sv
// Shared encodings for the compare pipeline: one-hot {gt,eq,lt} result codes.
package compar_pkg;
  localparam logic [2:0] CMP_GT = 3'b100;
  localparam logic [2:0] CMP_EQ = 3'b010;
  localparam logic [2:0] CMP_LT = 3'b001;
endpackage

// File: rtl/compar_core.sv
// Combinational signed/unsigned magnitude compare producing one-hot {gt,eq,lt}.
// Zero latency; no handshake, purely combinational.
module compar_core
  import compar_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_sgn,
  output logic [2:0]       o_cmp
);
  logic [WIDTH-1:0] w_a;
  logic [WIDTH-1:0] w_b;

  // Inverting the sign bit maps two's-complement ordering onto unsigned ordering.
  assign w_a = {i_a[WIDTH-1] ^ i_sgn, i_a[WIDTH-2:0]};
  assign w_b = {i_b[WIDTH-1] ^ i_sgn, i_b[WIDTH-2:0]};

  always_comb begin
    o_cmp = CMP_EQ;
    if (w_a > w_b) begin
      o_cmp = CMP_GT;
    end else if (w_a < w_b) begin
      o_cmp = CMP_LT;
    end
  end
endmodule

// File: rtl/compar_pipe.sv
// Two-stage pipelined comparator with running min/max/count over delivered pairs.
// Latency 2 cycles, 1 pair/cycle; stalls hold both stages and drop in_ready when full.
module compar_pipe
  import compar_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sgn,
  input  logic             run_clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             gt,
  output logic             eq,
  output logic             lt,
  output logic [WIDTH-1:0] max_ab,
  output logic [WIDTH-1:0] min_ab,
  output logic [WIDTH-1:0] run_max,
  output logic [WIDTH-1:0] run_min,
  output logic [CNT_W-1:0] run_cnt
);
  logic             r_s1_v;
  logic [WIDTH-1:0] r_s1_a;
  logic [WIDTH-1:0] r_s1_b;
  logic             r_s1_sgn;
  logic             r_s2_v;
  logic [2:0]       r_s2_cmp;
  logic [WIDTH-1:0] r_s2_max;
  logic [WIDTH-1:0] r_s2_min;
  logic             r_s2_sgn;
  logic [WIDTH-1:0] r_run_max;
  logic [WIDTH-1:0] r_run_min;
  logic [CNT_W-1:0] r_run_cnt;
  logic             r_run_empty;

  logic             w_adv1;
  logic             w_adv2;
  logic             w_out_xfer;
  logic             w_seed;
  logic [2:0]       w_pair_cmp;
  logic [2:0]       w_max_cmp;
  logic [2:0]       w_min_cmp;

  assign w_adv2     = !r_s2_v || out_ready;
  assign w_adv1     = !r_s1_v || w_adv2;
  assign in_ready   = w_adv1;
  assign w_out_xfer = r_s2_v && out_ready;
  assign w_seed     = r_run_empty || run_clr;

  compar_core #(.WIDTH(WIDTH)) u_pair (
    .i_a(r_s1_a), .i_b(r_s1_b), .i_sgn(r_s1_sgn), .o_cmp(w_pair_cmp)
  );
  compar_core #(.WIDTH(WIDTH)) u_max (
    .i_a(r_s2_max), .i_b(r_run_max), .i_sgn(r_s2_sgn), .o_cmp(w_max_cmp)
  );
  compar_core #(.WIDTH(WIDTH)) u_min (
    .i_a(r_s2_min), .i_b(r_run_min), .i_sgn(r_s2_sgn), .o_cmp(w_min_cmp)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_v   <= 1'b0;
      r_s1_a   <= '0;
      r_s1_b   <= '0;
      r_s1_sgn <= 1'b0;
      r_s2_v   <= 1'b0;
      r_s2_cmp <= 3'b000;
      r_s2_max <= '0;
      r_s2_min <= '0;
      r_s2_sgn <= 1'b0;
    end else begin
      if (w_adv1) begin
        r_s1_v <= in_valid;
        if (in_valid) begin
          r_s1_a   <= a;
          r_s1_b   <= b;
          r_s1_sgn <= sgn;
        end
      end
      if (w_adv2) begin
        r_s2_v <= r_s1_v;
        if (r_s1_v) begin
          r_s2_cmp <= w_pair_cmp;
          r_s2_max <= (w_pair_cmp == CMP_LT) ? r_s1_b : r_s1_a;
          r_s2_min <= (w_pair_cmp == CMP_LT) ? r_s1_a : r_s1_b;
          r_s2_sgn <= r_s1_sgn;
        end
      end
    end
  end

  // A clear that coincides with a delivery lets that pair seed the fresh statistics.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_run_max   <= '0;
      r_run_min   <= '0;
      r_run_cnt   <= '0;
      r_run_empty <= 1'b1;
    end else if (w_out_xfer) begin
      r_run_empty <= 1'b0;
      if (run_clr) begin
        r_run_cnt <= CNT_W'(1);
      end else if (r_run_cnt != '1) begin
        r_run_cnt <= r_run_cnt + CNT_W'(1);
      end
      if (w_seed || w_max_cmp == CMP_GT) begin
        r_run_max <= r_s2_max;
      end
      if (w_seed || w_min_cmp == CMP_LT) begin
        r_run_min <= r_s2_min;
      end
    end else if (run_clr) begin
      r_run_max   <= '0;
      r_run_min   <= '0;
      r_run_cnt   <= '0;
      r_run_empty <= 1'b1;
    end
  end

  assign out_valid = r_s2_v;
  assign gt        = r_s2_v && r_s2_cmp[2];
  assign eq        = r_s2_v && r_s2_cmp[1];
  assign lt        = r_s2_v && r_s2_cmp[0];
  assign max_ab    = r_s2_max;
  assign min_ab    = r_s2_min;
  assign run_max   = r_run_max;
  assign run_min   = r_run_min;
  assign run_cnt   = r_run_cnt;
endmodule

// File: tb/tb_compar_pipe.sv
// Directed plus randomized bench for compar_pipe at WIDTH=4, CNT_W=3 against a queue/arithmetic model.
module tb_compar_pipe;
  localparam int W  = 4;
  localparam int CW = 3;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         sgn = 1'b0;
  logic         run_clr = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic         gt, eq, lt;
  logic [W-1:0] max_ab, min_ab, run_max, run_min;
  logic [CW-1:0] run_cnt;

  compar_pipe #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .sgn(sgn), .run_clr(run_clr), .out_valid(out_valid),
    .out_ready(out_ready), .gt(gt), .eq(eq), .lt(lt), .max_ab(max_ab),
    .min_ab(min_ab), .run_max(run_max), .run_min(run_min), .run_cnt(run_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]   cmp;
    logic [W-1:0] mx;
    logic [W-1:0] mn;
    logic         s;
  } exp_t;

  exp_t         q[$];
  logic [W-1:0] m_max = '0;
  logic [W-1:0] m_min = '0;
  int           m_cnt = 0;
  bit           m_empty = 1'b1;
  int           n_out = 0;
  int           checks = 0;
  int           errors = 0;
  logic         l_ov, l_ir;
  logic [2:0]   l_cmp;
  logic [W-1:0] l_max, l_min;

  function automatic int val(input logic [W-1:0] x, input logic s);
    return (s && x[W-1]) ? int'(x) - (1 << W) : int'(x);
  endfunction

  function automatic exp_t mk(input logic [W-1:0] xa, input logic [W-1:0] xb, input logic s);
    exp_t e;
    int va = val(xa, s);
    int vb = val(xb, s);
    e.cmp = (va > vb) ? 3'b100 : (va == vb) ? 3'b010 : 3'b001;
    e.mx  = (va >= vb) ? xa : xb;
    e.mn  = (va >= vb) ? xb : xa;
    e.s   = s;
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic fail_now(input string tag);
    checks++;
    errors++;
    $error("FAIL %s: bounded wait expired", tag);
  endtask

  task automatic model_reset();
    q.delete();
    m_max = '0;
    m_min = '0;
    m_cnt = 0;
    m_empty = 1'b1;
  endtask

  // One clock: sample mid-cycle, check against the model, then apply this edge's effects.
  task automatic cyc(output bit ix);
    bit   ox;
    exp_t e;
    @(negedge clk);
    ix = in_valid && in_ready;
    ox = out_valid && out_ready;
    l_ov = out_valid; l_ir = in_ready; l_cmp = {gt, eq, lt}; l_max = max_ab; l_min = min_ab;
    chk("run_max", 32'(run_max), 32'(m_max));
    chk("run_min", 32'(run_min), 32'(m_min));
    chk("run_cnt", 32'(run_cnt), 32'(m_cnt));
    if (out_valid) begin
      if (q.size() == 0) begin
        fail_now("spurious_out_valid");
      end else begin
        chk("cmp", 32'({gt, eq, lt}), 32'(q[0].cmp));
        chk("max_ab", 32'(max_ab), 32'(q[0].mx));
        chk("min_ab", 32'(min_ab), 32'(q[0].mn));
      end
    end else begin
      chk("idle_flags", 32'({gt, eq, lt}), 32'(3'b000));
    end
    @(posedge clk);
    if (ox && q.size() > 0) begin
      e = q.pop_front();
      n_out++;
      if (run_clr || m_empty) begin
        m_max = e.mx;
        m_min = e.mn;
      end else begin
        if (val(e.mx, e.s) > val(m_max, e.s)) m_max = e.mx;
        if (val(e.mn, e.s) < val(m_min, e.s)) m_min = e.mn;
      end
      m_cnt = run_clr ? 1 : ((m_cnt < CNT_MAX) ? m_cnt + 1 : CNT_MAX);
      m_empty = 1'b0;
    end else if (run_clr) begin
      m_max = '0; m_min = '0; m_cnt = 0; m_empty = 1'b1;
    end
    if (ix) q.push_back(mk(a, b, sgn));
    #1;
  endtask

  task automatic tick();
    bit d;
    cyc(d);
  endtask

  task automatic send(input logic [W-1:0] xa, input logic [W-1:0] xb, input logic s);
    bit ix = 1'b0;
    in_valid = 1'b1; a = xa; b = xb; sgn = s;
    for (int i = 0; i < 50 && !ix; i++) cyc(ix);
    if (!ix) fail_now("send_accept");
    in_valid = 1'b0;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    in_valid = 1'b0;
    for (int i = 0; i < 20 && q.size() > 0; i++) tick();
    if (q.size() > 0) fail_now("drain");
  endtask

  // Single pair into an empty pipe with out_ready=1: result appears exactly two cycles later.
  task automatic one(input logic [W-1:0] xa, input logic [W-1:0] xb, input logic s,
                     input logic [2:0] ecmp, input logic [W-1:0] emax, input logic [W-1:0] emin);
    out_ready = 1'b1;
    in_valid = 1'b1; a = xa; b = xb; sgn = s;
    tick();
    in_valid = 1'b0;
    tick();
    chk("lat_gap", 32'(l_ov), 32'(1'b0));
    tick();
    chk("lat_ov", 32'(l_ov), 32'(1'b1));
    chk("dir_cmp", 32'(l_cmp), 32'(ecmp));
    chk("dir_max", 32'(l_max), 32'(emax));
    chk("dir_min", 32'(l_min), 32'(emin));
  endtask

  initial begin
    bit ix;
    int k;
    int base;

    #1;
    chk("rst_out_valid", 32'(out_valid), 32'(1'b0));
    chk("rst_flags", 32'({gt, eq, lt}), 32'(3'b000));
    chk("rst_max_ab", 32'(max_ab), 32'(4'b0000));
    chk("rst_min_ab", 32'(min_ab), 32'(4'b0000));
    chk("rst_stats", 32'({run_max, run_min, run_cnt}), 32'(0));
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("rel_in_ready", 32'(in_ready), 32'(1'b1));

    one(4'b1000, 4'b1011, 1'b1, 3'b001, 4'b1011, 4'b1000);
    one(4'b0101, 4'b1111, 1'b1, 3'b100, 4'b0101, 4'b1111);
    one(4'b0101, 4'b1111, 1'b0, 3'b001, 4'b1111, 4'b0101);
    one(4'b0111, 4'b0111, 1'b0, 3'b010, 4'b0111, 4'b0111);

    // Four back-to-back pairs with a three-cycle consumer stall.
    base = n_out;
    k = 0;
    for (int c = 0; c < 12; c++) begin
      out_ready = !(c >= 3 && c < 6);
      in_valid = (k < 4);
      a = 4'(k * 3 + 1); b = 4'(9 - k); sgn = k[0];
      cyc(ix);
      if (c == 3 || c == 4) chk("stall_in_ready", 32'(l_ir), 32'(1'b0));
      if (ix) k++;
    end
    in_valid = 1'b0;
    drain();
    chk("stall_delivered", 32'(n_out - base), 32'(4));

    // Randomized traffic with random backpressure and occasional clears.
    for (int c = 0; c < 400; c++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      run_clr = ($urandom_range(0, 19) == 0);
      a = 4'($urandom);
      b = ($urandom_range(0, 7) == 0) ? a : 4'($urandom);
      sgn = 1'($urandom);
      tick();
    end
    run_clr = 1'b0;
    drain();

    out_ready = 1'b1;
    run_clr = 1'b1;
    tick();
    run_clr = 1'b0;
    chk("clr_stats", 32'({run_max, run_min, run_cnt}), 32'(0));
    send(4'd2, 4'd7, 1'b1);
    send(4'b1000, 4'b1011, 1'b1);
    send(4'd5, 4'b1111, 1'b1);
    drain();
    chk("seq_run_max", 32'(run_max), 32'(4'b0111));
    chk("seq_run_min", 32'(run_min), 32'(4'b1000));
    chk("seq_run_cnt", 32'(run_cnt), 32'(3'd3));
    for (int i = 0; i < 10; i++) send(4'($urandom), 4'($urandom), 1'($urandom));
    drain();
    chk("sat_run_cnt", 32'(run_cnt), 32'(3'b111));

    // Clear lands on the very cycle (3,1) is delivered.
    out_ready = 1'b1;
    in_valid = 1'b1; a = 4'd3; b = 4'd1; sgn = 1'b0;
    tick();
    in_valid = 1'b0;
    tick();
    run_clr = 1'b1;
    tick();
    run_clr = 1'b0;
    chk("clrx_ov", 32'(l_ov), 32'(1'b1));
    chk("clrx_run_max", 32'(run_max), 32'(4'b0011));
    chk("clrx_run_min", 32'(run_min), 32'(4'b0001));
    chk("clrx_run_cnt", 32'(run_cnt), 32'(3'd1));

    // Reset with both stages occupied and the consumer stalled.
    out_ready = 1'b0;
    send(4'd1, 4'd2, 1'b0);
    send(4'd3, 4'd4, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", 32'(out_valid), 32'(1'b0));
    chk("mid_rst_flags", 32'({gt, eq, lt}), 32'(3'b000));
    chk("mid_rst_stats", 32'({run_max, run_min, run_cnt}), 32'(0));
    model_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;
    chk("post_rst_in_ready", 32'(in_ready), 32'(1'b1));
    one(4'b1001, 4'b0010, 1'b1, 3'b001, 4'b0010, 4'b1001);
    tick();
    chk("post_rst_no_stale", 32'(l_ov), 32'(1'b0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
